// File: rtl/arcade_pkg.sv
// Shared arcade video types, the colour-key default and the built-in sprite image.
package arcade_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef logic signed [11:0] coord_t;

  localparam logic [11:0] TRANSPARENT_DEFAULT = 12'hFFF;

  // Procedural sprite image: a gradient with marker texels on row 0 of the early frames.
  function automatic logic [11:0] sprite_texel(input int frame, input int row,
                                               input int col, input int spr_w);
    logic [11:0] t;
    t = {4'(frame * 3 + col / 16), 4'(row), 4'(col)};
    if (row == 0 && col == 0 && frame == 0) t = 12'h0F0;
    else if (row == 0 && col == 0 && frame == 1) t = 12'hFFF;
    else if (row == 0 && col == spr_w - 1) t = 12'h123;
    return t;
  endfunction

endpackage

// File: rtl/sprite_rom.sv
// Synchronous single-port sprite ROM: address registered on clk, data one cycle later.
module sprite_rom
  import arcade_pkg::*;
#(
  parameter int FRAMES = 4,
  parameter int SPR_W  = 128,
  parameter int SPR_H  = 64,
  localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  localparam int RB = $clog2(SPR_H),
  localparam int CB = $clog2(SPR_W),
  localparam int AW = FW + RB + CB
)(
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output logic [11:0]   q
);

  logic [AW-1:0] addr_q;

  always_ff @(posedge clk) begin
    addr_q <= addr;
  end

  assign q = sprite_texel(int'(addr_q[AW-1 -: FW]), int'(addr_q[CB +: RB]),
                          int'(addr_q[CB-1:0]), SPR_W);

endmodule

// File: rtl/draw_sprite_anim.sv
// Animated, scaled, mirrorable sprite renderer with a 2-clock pixel pipeline.
module draw_sprite_anim
  import arcade_pkg::*;
#(
  parameter int          SPR_W       = 128,
  parameter int          SPR_H       = 64,
  parameter int          FRAMES      = 4,
  parameter int          FRAME_DIV   = 8,
  parameter logic [11:0] TRANSPARENT = TRANSPARENT_DEFAULT,
  localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1
)(
  input  logic          clk,
  input  logic          resetN,
  input  logic [10:0]   pxl_x,
  input  logic [10:0]   pxl_y,
  input  coord_t        topLeft_x,
  input  coord_t        topLeft_y,
  input  logic [1:0]    scale,
  input  logic          flip_x,
  input  logic          visible,
  input  logic          startOfFrame,
  input  logic          anim_en,
  input  logic          oneshot,
  input  logic          anim_restart,
  input  logic [FW-1:0] frame_sel,
  output logic [3:0]    Red_level,
  output logic [3:0]    Green_level,
  output logic [3:0]    Blue_level,
  output logic          Drawing,
  output logic [FW-1:0] cur_frame,
  output logic          anim_done
);

  localparam int CB = $clog2(SPR_W);
  localparam int RB = $clog2(SPR_H);
  localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(FRAME_DIV - 1);

  logic [1:0]         scale_eff;
  logic signed [12:0] off_x, off_y;
  logic [13:0]        lim_x, lim_y;
  logic               hit, hit_d;
  logic [CB-1:0]      col, col_raw;
  logic [RB-1:0]      row;
  logic [11:0]        rom_q;
  logic [FW-1:0]      frame_inc;
  logic [DW-1:0]      div_cnt;
  logic               stopped;
  rgb444_t            pix_q;

  assign scale_eff = (scale == 2'd3) ? 2'd2 : scale;
  assign off_x = $signed({2'b00, pxl_x}) - $signed({topLeft_x[11], topLeft_x});
  assign off_y = $signed({2'b00, pxl_y}) - $signed({topLeft_y[11], topLeft_y});
  assign lim_x = 14'(SPR_W) << scale_eff;
  assign lim_y = 14'(SPR_H) << scale_eff;

  assign hit = visible & ~off_x[12] & ({2'b00, off_x[11:0]} < lim_x)
                       & ~off_y[12] & ({2'b00, off_y[11:0]} < lim_y);

  // Mirroring within a power-of-two width is a bitwise inversion of the column.
  assign col_raw = CB'(off_x[11:0] >> scale_eff);
  assign col     = flip_x ? ~col_raw : col_raw;
  assign row     = RB'(off_y[11:0] >> scale_eff);

  sprite_rom #(
    .FRAMES (FRAMES),
    .SPR_W  (SPR_W),
    .SPR_H  (SPR_H)
  ) u_rom (
    .clk  (clk),
    .addr ({cur_frame, row, col}),
    .q    (rom_q)
  );

  assign frame_inc = cur_frame + 1'b1;

  // Animation only steps on start-of-frame so a frame swap never tears mid-screen.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cur_frame <= '0;
      div_cnt   <= '0;
      stopped   <= 1'b0;
      anim_done <= 1'b0;
    end else begin
      anim_done <= 1'b0;
      if (anim_restart) begin
        cur_frame <= '0;
        div_cnt   <= '0;
        stopped   <= 1'b0;
      end else if (startOfFrame) begin
        if (!anim_en) begin
          cur_frame <= (FRAMES > 1) ? frame_sel : '0;
          div_cnt   <= '0;
        end else if (stopped) begin
          if (!oneshot) stopped <= 1'b0;
        end else if (div_cnt != DIV_LAST) begin
          div_cnt <= div_cnt + 1'b1;
        end else begin
          div_cnt <= '0;
          if (oneshot && (cur_frame == FRAME_LAST || frame_inc == FRAME_LAST)) begin
            cur_frame <= FRAME_LAST;
            stopped   <= 1'b1;
            anim_done <= 1'b1;
          end else if (cur_frame == FRAME_LAST) begin
            cur_frame <= '0;
          end else begin
            cur_frame <= frame_inc;
          end
        end
      end
    end
  end

  // hit is delayed to line up with the ROM data; colour holds while not drawing.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hit_d   <= 1'b0;
      Drawing <= 1'b0;
      pix_q   <= '0;
    end else begin
      hit_d <= hit;
      if (hit_d && rom_q != TRANSPARENT) begin
        Drawing <= 1'b1;
        pix_q   <= rgb444_t'(rom_q);
      end else begin
        Drawing <= 1'b0;
      end
    end
  end

  assign Red_level   = pix_q.r;
  assign Green_level = pix_q.g;
  assign Blue_level  = pix_q.b;

endmodule

// File: tb/tb_draw_sprite_anim.sv
// Self-checking bench for draw_sprite_anim: per-cycle model compare plus pinned literal checks.
module tb_draw_sprite_anim;

  localparam int SPR_W = 128, SPR_H = 64, FRAMES = 4, FRAME_DIV = 8, FW = 2;

  logic              clk, resetN;
  logic [10:0]       pxl_x, pxl_y;
  logic signed [11:0] topLeft_x, topLeft_y;
  logic [1:0]        scale;
  logic              flip_x, visible, startOfFrame, anim_en, oneshot, anim_restart;
  logic [FW-1:0]     frame_sel;
  logic [3:0]        Red_level, Green_level, Blue_level;
  logic              Drawing, anim_done;
  logic [FW-1:0]     cur_frame;

  int tests = 0;
  int fails = 0;
  bit chk_on = 0;

  draw_sprite_anim #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .FRAMES(FRAMES), .FRAME_DIV(FRAME_DIV), .TRANSPARENT(12'hFFF)
  ) dut (
    .clk(clk), .resetN(resetN), .pxl_x(pxl_x), .pxl_y(pxl_y),
    .topLeft_x(topLeft_x), .topLeft_y(topLeft_y), .scale(scale), .flip_x(flip_x),
    .visible(visible), .startOfFrame(startOfFrame), .anim_en(anim_en), .oneshot(oneshot),
    .anim_restart(anim_restart), .frame_sel(frame_sel), .Red_level(Red_level),
    .Green_level(Green_level), .Blue_level(Blue_level), .Drawing(Drawing),
    .cur_frame(cur_frame), .anim_done(anim_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference image, stated independently of the RTL package.
  function automatic logic [11:0] image_texel(input int f, input int r, input int c);
    if (r == 0 && c == 0 && f == 0) return 12'h0F0;
    if (r == 0 && c == 0 && f == 1) return 12'hFFF;
    if (r == 0 && c == SPR_W - 1) return 12'h123;
    return {4'(3 * f + c / 16), 4'(r % 16), 4'(c % 16)};
  endfunction

  function automatic int eff_scale();
    return (scale == 2'd3) ? 2 : int'(scale);
  endfunction

  function automatic bit pix_hit();
    int ox, oy, mag;
    mag = 1 << eff_scale();
    ox = int'(pxl_x) - int'(topLeft_x);
    oy = int'(pxl_y) - int'(topLeft_y);
    return visible && ox >= 0 && ox < SPR_W * mag && oy >= 0 && oy < SPR_H * mag;
  endfunction

  function automatic logic [11:0] pix_texel(input int f);
    int ox, oy, mag, c, r;
    mag = 1 << eff_scale();
    ox = int'(pxl_x) - int'(topLeft_x);
    oy = int'(pxl_y) - int'(topLeft_y);
    if (ox < 0 || oy < 0) return 12'h000;
    c = ox / mag;
    r = oy / mag;
    if (flip_x) c = SPR_W - 1 - c;
    return image_texel(f, r, c);
  endfunction

  // Frame shown after 'steps' enabled SOFs from a starting frame 'base'.
  function automatic logic [FW-1:0] frame_of(input int base, input int steps, input logic os);
    int f;
    f = base + steps / FRAME_DIV;
    if (os) return FW'((f > FRAMES - 1) ? FRAMES - 1 : f);
    return FW'(f % FRAMES);
  endfunction

  logic          m_hit1, m_draw, m_done;
  logic [11:0]   m_tex1, m_rgb;
  logic [FW-1:0] m_frame;
  int            m_base, m_steps;

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_hit1 <= 1'b0; m_tex1 <= '0; m_draw <= 1'b0; m_rgb <= '0;
      m_frame <= '0; m_done <= 1'b0; m_base <= 0; m_steps <= 0;
    end else begin
      m_hit1 <= pix_hit();
      m_tex1 <= pix_texel(int'(m_frame));
      if (m_hit1 && m_tex1 != 12'hFFF) begin
        m_draw <= 1'b1;
        m_rgb  <= m_tex1;
      end else begin
        m_draw <= 1'b0;
      end
      m_done <= 1'b0;
      if (anim_restart) begin
        m_base <= 0; m_steps <= 0; m_frame <= '0;
      end else if (startOfFrame) begin
        if (!anim_en) begin
          m_base <= int'(frame_sel); m_steps <= 0; m_frame <= frame_sel;
        end else begin
          m_steps <= m_steps + 1;
          m_frame <= frame_of(m_base, m_steps + 1, oneshot);
          if (oneshot && m_steps + 1 == (FRAMES - 1 - m_base) * FRAME_DIV) m_done <= 1'b1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      checkOutput("model Drawing", 12'(Drawing), 12'(m_draw));
      checkOutput("model RGB", {Red_level, Green_level, Blue_level}, m_rgb);
      checkOutput("model cur_frame", 12'(cur_frame), 12'(m_frame));
      checkOutput("model anim_done", 12'(anim_done), 12'(m_done));
    end
  end

  task automatic applyStimulus(input int x, input int y);
    @(posedge clk); #1;
    pxl_x = 11'(x);
    pxl_y = 11'(y);
  endtask

  task automatic pixelCheck(input string name, input int x, input int y,
                            input logic exp_draw, input logic [11:0] exp_rgb);
    applyStimulus(x, y);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput({name, " Drawing"}, 12'(Drawing), 12'(exp_draw));
    checkOutput({name, " RGB"}, {Red_level, Green_level, Blue_level}, exp_rgb);
  endtask

  task automatic sof();
    @(posedge clk); #1 startOfFrame = 1'b1;
    @(posedge clk); #1 startOfFrame = 1'b0;
  endtask

  task automatic restart(input logic with_sof);
    @(posedge clk); #1 anim_restart = 1'b1; startOfFrame = with_sof;
    @(posedge clk); #1 anim_restart = 1'b0; startOfFrame = 1'b0;
  endtask

  int sw_tx[4] = '{-8, 600, 20, 1000};
  int sw_ty[4] = '{-4, 10, 40, 300};
  int done_cnt, done_at;

  initial begin
    #1000000;
    fails++;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    resetN = 1'b0; pxl_x = '0; pxl_y = '0; topLeft_x = '0; topLeft_y = '0;
    scale = '0; flip_x = 1'b0; visible = 1'b0; startOfFrame = 1'b0;
    anim_en = 1'b0; oneshot = 1'b0; anim_restart = 1'b0; frame_sel = '0;
    #3;
    checkOutput("reset Drawing", 12'(Drawing), 12'h0);
    checkOutput("reset RGB", {Red_level, Green_level, Blue_level}, 12'h000);
    checkOutput("reset cur_frame", 12'(cur_frame), 12'h0);
    checkOutput("reset anim_done", 12'(anim_done), 12'h0);
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;
    chk_on = 1'b1;

    // Geometry and latency
    sof();
    topLeft_x = 12'sd100; topLeft_y = 12'sd50; visible = 1'b1;
    pixelCheck("origin", 100, 50, 1'b1, 12'h0F0);
    pixelCheck("left of origin", 99, 50, 1'b0, 12'h0F0);

    // Transparency and flip on frame 1
    frame_sel = 2'd1; sof();
    flip_x = 1'b1;
    pixelCheck("flip origin", 100, 50, 1'b1, 12'h123);
    flip_x = 1'b0;
    pixelCheck("transparent origin", 100, 50, 1'b0, 12'h123);

    // Scaling and clipping on frame 0
    frame_sel = 2'd0; sof();
    scale = 2'd2; topLeft_x = -12'sd8; topLeft_y = 12'sd0;
    pixelCheck("scaled col2", 0, 0, 1'b1, 12'h002);
    pixelCheck("scaled right edge", 503, 0, 1'b1, 12'h123);
    pixelCheck("scaled past edge", 504, 0, 1'b0, 12'h123);
    scale = 2'd3;
    pixelCheck("scale3 right edge", 503, 0, 1'b1, 12'h123);
    visible = 1'b0;
    pixelCheck("invisible", 0, 0, 1'b0, 12'h123);
    visible = 1'b1;

    // Edge-crossing sweeps checked by the model
    for (int c = 0; c < 4; c++) begin
      topLeft_x = 12'(sw_tx[c]); topLeft_y = 12'(sw_ty[c]);
      scale = 2'(c); flip_x = c[0];
      for (int i = 0; i < 40; i++)
        applyStimulus((sw_tx[c] - 20 + i * 13) & 2047, (sw_ty[c] - 5 + i * 7) & 2047);
    end
    topLeft_x = 12'sd100; topLeft_y = 12'sd50; scale = 2'd0; flip_x = 1'b0;
    applyStimulus(110, 53);

    // Looping animation
    anim_en = 1'b1; oneshot = 1'b0;
    restart(1'b0);
    done_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      sof();
      @(negedge clk);
      if (anim_done) done_cnt++;
      if (k == 8)  checkOutput("loop frame@8", 12'(cur_frame), 12'h1);
      if (k == 24) checkOutput("loop frame@24", 12'(cur_frame), 12'h3);
      if (k == 32) checkOutput("loop frame@32", 12'(cur_frame), 12'h0);
    end
    checkOutput("loop anim_done count", 12'(done_cnt), 12'h0);

    // One-shot animation
    @(posedge clk); #1 anim_restart = 1'b1; oneshot = 1'b1;
    @(posedge clk); #1 anim_restart = 1'b0;
    done_cnt = 0; done_at = -1;
    for (int k = 1; k <= 32; k++) begin
      sof();
      @(negedge clk);
      if (anim_done) begin
        done_cnt++;
        done_at = k;
      end
    end
    checkOutput("oneshot done count", 12'(done_cnt), 12'h1);
    checkOutput("oneshot done SOF", 12'(done_at), 12'd24);
    checkOutput("oneshot final frame", 12'(cur_frame), 12'h3);

    // Restart coincident with SOF clears frame and divider
    restart(1'b1);
    @(negedge clk);
    checkOutput("restart frame", 12'(cur_frame), 12'h0);
    for (int k = 1; k <= 8; k++) begin
      sof();
      @(negedge clk);
      if (k == 7) checkOutput("restart div frame@7", 12'(cur_frame), 12'h0);
      if (k == 8) checkOutput("restart div frame@8", 12'(cur_frame), 12'h1);
    end

    // Static frame select
    anim_en = 1'b0; frame_sel = 2'd2;
    sof();
    @(negedge clk);
    checkOutput("static frame", 12'(cur_frame), 12'h2);
    pixelCheck("frame2 texel", 105, 52, 1'b1, 12'h625);

    // Asynchronous reset mid-line
    @(posedge clk); #2 resetN = 1'b0;
    #1;
    checkOutput("async reset Drawing", 12'(Drawing), 12'h0);
    checkOutput("async reset RGB", {Red_level, Green_level, Blue_level}, 12'h000);
    checkOutput("async reset cur_frame", 12'(cur_frame), 12'h0);
    checkOutput("async reset anim_done", 12'(anim_done), 12'h0);
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;
    pixelCheck("post-reset texel", 105, 52, 1'b1, 12'h025);
    for (int i = 0; i < 8; i++) applyStimulus(95 + i * 3, 50 + i);
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
